// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_pkg
//  Description : Shared types and constants for the ADC scan sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        REQ    = 3'd2,
        GAP    = 3'd3,
        EMIT   = 3'd4,
        DONE   = 3'd5
    } adc_state_t;

    localparam int c_def_num_ch   = 4;
    localparam int c_def_data_w   = 16;
    localparam int c_def_avg_log2 = 2;
    localparam int c_def_timeout  = 2000;

    // ADS1115 at the +/-4.096 V range: 32768 codes span 4.096 V
    localparam int c_ads1115_fs_uv    = 4096000;
    localparam int c_ads1115_fs_codes = 32768;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_scan_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : adc_scan_controller_if
//  Description : Conversion request/acknowledge bus to the ADC front-end.
//  Revision    : 1.0 - initial release
// ============================================================================
interface adc_scan_controller_if
    import adc_pkg::*;
#(
    parameter int CH_W   = ch_width(c_def_num_ch),
    parameter int DATA_W = c_def_data_w
);
    logic              conv_req;
    logic [CH_W-1:0]   conv_ch;
    logic              conv_ack;
    logic [DATA_W-1:0] conv_data;

    modport master (output conv_req, output conv_ch, input conv_ack, input conv_data);
    modport slave  (input conv_req, input conv_ch, output conv_ack, output conv_data);
endinterface
`default_nettype wire

// File: rtl/adc_ch_select.sv
`default_nettype none
// ============================================================================
//  Module      : adc_ch_select
//  Description : Lowest enabled channel at or above a scan pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_ch_select
    import adc_pkg::*;
#(
    parameter int NUM_CH = c_def_num_ch,
    parameter int CH_W   = ch_width(c_def_num_ch),
    parameter int PTR_W  = $clog2(c_def_num_ch + 1)
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [PTR_W-1:0]  ptr,
    output logic              found,
    output logic [CH_W-1:0]   ch
);

    // Walk downward so the lowest qualifying channel is the last one written
    always_comb begin
        found = 1'b0;
        ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (PTR_W'(i) >= ptr)) begin
                found = 1'b1;
                ch    = CH_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : adc_scan_controller
//  Description : Multi-channel oversampling ADC scan sequencer with threshold
//                flags and conversion timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_controller
    import adc_pkg::*;
#(
    parameter int NUM_CH   = c_def_num_ch,
    parameter int DATA_W   = c_def_data_w,
    parameter int AVG_LOG2 = c_def_avg_log2,
    parameter int TIMEOUT  = c_def_timeout
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          mode,
    input  logic [NUM_CH-1:0]             ch_enable,
    input  logic signed [DATA_W-1:0]      thresh,
    adc_scan_controller_if.master         conv,
    output logic                          result_valid,
    output logic [ch_width(NUM_CH)-1:0]   result_ch,
    output logic signed [DATA_W-1:0]      result_data,
    output logic [NUM_CH-1:0]             over_flags,
    output logic                          scan_done,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int CH_W  = ch_width(NUM_CH);
    localparam int PTR_W = $clog2(NUM_CH + 1);
    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT - 1);

    adc_state_t r_state, w_state_nxt;

    logic                     r_mode;
    logic                     r_stop_pending;
    logic                     r_timeout_err;
    logic [NUM_CH-1:0]        r_mask;
    logic [PTR_W-1:0]         r_ptr;
    logic [CH_W-1:0]          r_ch;
    logic signed [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]         r_cnt;
    logic [TMO_W-1:0]         r_tmo;
    logic [NUM_CH-1:0]        r_over;
    logic [CH_W-1:0]          r_result_ch;
    logic signed [DATA_W-1:0] r_result_data;

    logic                     w_found;
    logic [CH_W-1:0]          w_sel_ch;
    logic                     w_start_ok;
    logic                     w_ack_last;
    logic                     w_tmo_hit;
    logic signed [ACC_W-1:0]  w_acc_sum;
    logic signed [DATA_W-1:0] w_result;
    logic                     w_conv_req;
    logic                     w_result_valid;
    logic                     w_scan_done;
    logic                     w_busy;

    adc_ch_select #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .PTR_W  (PTR_W)
    ) u_ch_select (
        .mask   (r_mask),
        .ptr    (r_ptr),
        .found  (w_found),
        .ch     (w_sel_ch)
    );

    assign w_start_ok = start && (|ch_enable);
    assign w_ack_last = conv.conv_ack && (r_cnt == c_last_cnt);
    assign w_tmo_hit  = (r_tmo == c_tmo_last);
    assign w_acc_sum  = r_acc + ACC_W'($signed(conv.conv_data));
    // Arithmetic shift floors toward -inf; the mean of DATA_W codes fits DATA_W
    assign w_result   = DATA_W'(w_acc_sum >>> AVG_LOG2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_conv_req     = 1'b0;
        w_result_valid = 1'b0;
        w_scan_done    = 1'b0;
        w_busy         = 1'b1;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (w_start_ok) w_state_nxt = SELECT;
            end
            SELECT: w_state_nxt = w_found ? REQ : DONE;
            REQ: begin
                w_conv_req = 1'b1;
                // An ack in the last permitted cycle takes priority over the timeout
                if (conv.conv_ack)  w_state_nxt = w_ack_last ? EMIT : GAP;
                else if (w_tmo_hit) w_state_nxt = IDLE;
            end
            GAP:  w_state_nxt = REQ;
            EMIT: begin
                w_result_valid = 1'b1;
                w_state_nxt    = SELECT;
            end
            DONE: begin
                w_scan_done = 1'b1;
                w_state_nxt = (r_mode && !r_stop_pending) ? SELECT : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode         <= 1'b0;
            r_stop_pending <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_mask         <= '0;
            r_ptr          <= '0;
            r_ch           <= '0;
            r_acc          <= '0;
            r_cnt          <= '0;
            r_tmo          <= '0;
            r_over         <= '0;
            r_result_ch    <= '0;
            r_result_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_mode         <= mode;
                        r_mask         <= ch_enable;
                        r_timeout_err  <= 1'b0;
                        r_stop_pending <= 1'b0;
                        r_ptr          <= '0;
                        r_acc          <= '0;
                        r_cnt          <= '0;
                    end
                end
                SELECT: begin
                    r_tmo <= '0;
                    if (w_found) r_ch <= w_sel_ch;
                end
                REQ: begin
                    if (conv.conv_ack) begin
                        r_acc <= w_acc_sum;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_ack_last) begin
                            r_result_data <= w_result;
                            r_result_ch   <= r_ch;
                        end
                    end else if (w_tmo_hit) begin
                        r_timeout_err <= 1'b1;
                        r_acc         <= '0;
                        r_cnt         <= '0;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                GAP: r_tmo <= '0;
                EMIT: begin
                    r_over[r_ch] <= (r_result_data > thresh);
                    r_acc        <= '0;
                    r_cnt        <= '0;
                    r_ptr        <= PTR_W'(r_ch) + PTR_W'(1);
                end
                DONE: r_ptr <= '0;
                default: ;
            endcase
            if (stop && (r_state != IDLE)) r_stop_pending <= 1'b1;
        end
    end

    assign conv.conv_req = w_conv_req;
    assign conv.conv_ch  = r_ch;
    assign result_valid  = w_result_valid;
    assign result_ch     = r_result_ch;
    assign result_data   = r_result_data;
    assign over_flags    = r_over;
    assign scan_done     = w_scan_done;
    assign busy          = w_busy;
    assign timeout_err   = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_scan_controller
//  Description : Self-checking bench for adc_scan_controller with a front-end
//                responder model and a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_scan_controller;
    import adc_pkg::*;

    localparam int NUM_CH   = 4;
    localparam int DATA_W   = 16;
    localparam int AVG_LOG2 = 2;
    localparam int TIMEOUT  = 50;
    localparam int NSAMP    = 1 << AVG_LOG2;
    localparam int CH_W     = ch_width(NUM_CH);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     reset, start, stop, mode;
    logic [NUM_CH-1:0]        ch_enable;
    logic signed [DATA_W-1:0] thresh;
    logic                     result_valid, scan_done, busy, timeout_err;
    logic [CH_W-1:0]          result_ch;
    logic signed [DATA_W-1:0] result_data;
    logic [NUM_CH-1:0]        over_flags;

    adc_scan_controller_if #(.CH_W(CH_W), .DATA_W(DATA_W)) conv_if ();

    adc_scan_controller #(
        .NUM_CH   (NUM_CH),
        .DATA_W   (DATA_W),
        .AVG_LOG2 (AVG_LOG2),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .mode         (mode),
        .ch_enable    (ch_enable),
        .thresh       (thresh),
        .conv         (conv_if),
        .result_valid (result_valid),
        .result_ch    (result_ch),
        .result_data  (result_data),
        .over_flags   (over_flags),
        .scan_done    (scan_done),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    typedef struct packed {
        logic [NUM_CH-1:0]              mask;
        logic [DATA_W-1:0]              thresh;
        logic [7:0]                     delay;
        logic [NUM_CH*NSAMP-1:0][DATA_W-1:0] samp;
    } vec_t;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic [DATA_W-1:0] samp_q[$];
    exp_t              exp_q[$];
    vec_t              vecs[6];

    int n_vec = 0, n_err = 0, cyc = 0;
    int req_pulses, req_hi, rv_count, sd_count;
    int first_req_cyc, last_rv_cyc, last_sd_cyc;
    int ack_delay = 0, wait_cnt = 0;
    bit no_ack = 1'b0;
    logic prev_req = 1'b0;
    logic [NUM_CH-1:0] exp_flags = '0;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int floor_avg(input int sum);
        if (sum >= 0) return sum / NSAMP;
        return -((-sum + NSAMP - 1) / NSAMP);
    endfunction

    // One clock: sample DUT outputs at the falling edge, then drive the front-end
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (conv_if.conv_req) req_hi++;
        if (conv_if.conv_req && !prev_req) begin
            req_pulses++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
        end
        prev_req = conv_if.conv_req;
        if (result_valid) begin
            rv_count++;
            last_rv_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("result_expected", 32'(exp_q.size() > 0), 1);
            end else begin
                e = exp_q.pop_front();
                chk("res_ch", result_ch, e.ch);
                chk("res_data", result_data, $signed(e.data));
            end
        end
        if (scan_done) begin
            sd_count++;
            last_sd_cyc = cyc;
        end
        if (conv_if.conv_req && !no_ack) begin
            if (wait_cnt == ack_delay) begin
                conv_if.conv_ack  = 1'b1;
                conv_if.conv_data = (samp_q.size() > 0) ? samp_q.pop_front() : '0;
                wait_cnt = 0;
            end else begin
                conv_if.conv_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            conv_if.conv_ack = 1'b0;
            wait_cnt = 0;
        end
    endtask

    task automatic clear_counts();
        req_pulses = 0; req_hi = 0; rv_count = 0; sd_count = 0;
        first_req_cyc = -1; last_rv_cyc = 0; last_sd_cyc = 0;
        samp_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_idle_in_time"}, busy, 0);
    endtask

    task automatic push_ch(input int c, input logic [NSAMP-1:0][DATA_W-1:0] s);
        exp_t e;
        int   sum = 0;
        for (int k = 0; k < NSAMP; k++) begin
            samp_q.push_back(s[k]);
            sum += int'($signed(s[k]));
        end
        e.ch   = CH_W'(c);
        e.data = DATA_W'(floor_avg(sum));
        exp_q.push_back(e);
        exp_flags[c] = (floor_avg(sum) > int'(thresh));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int s, nen = 0;
        clear_counts();
        ch_enable = v.mask;
        thresh    = v.thresh;
        mode      = 1'b0;
        ack_delay = int'(v.delay);
        for (int c = 0; c < NUM_CH; c++) begin
            if (v.mask[c]) begin
                nen++;
                push_ch(c, v.samp[c*NSAMP +: NSAMP]);
            end
        end
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
        wait_idle(3000, tag);
        tick();
        chk({tag, "_results_left"}, exp_q.size(), 0);
        chk({tag, "_req_pulses"}, req_pulses, nen * NSAMP);
        chk({tag, "_scan_done"}, sd_count, 1);
        chk({tag, "_done_latency"}, last_sd_cyc - last_rv_cyc, 2);
        chk({tag, "_first_req"}, first_req_cyc - s, 2);
        chk({tag, "_flags"}, over_flags, exp_flags);
    endtask

    initial begin
        logic [DATA_W-1:0] fs_pos, fs_neg;
        logic [NSAMP-1:0][DATA_W-1:0] s4;
        int n;
        bit busy_seen;

        reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
        ch_enable = '0; thresh = '0;
        conv_if.conv_ack = 1'b0; conv_if.conv_data = '0;
        fs_pos = DATA_W'(c_ads1115_fs_codes - 1);
        fs_neg = DATA_W'(-c_ads1115_fs_codes);

        for (int i = 0; i < 6; i++)
            for (int k = 0; k < NUM_CH * NSAMP; k++)
                vecs[i].samp[k] = DATA_W'($urandom);
        vecs[0].mask = 4'b0101; vecs[0].thresh = 16'd0;       vecs[0].delay = 8'd3;
        vecs[0].samp[3:0]   = {16'd106, 16'd104, 16'd102, 16'd100};
        vecs[0].samp[11:8]  = {16'd41, 16'd30, 16'd20, 16'd10};
        vecs[1].mask = 4'b0010; vecs[1].thresh = 16'hFFFD;    vecs[1].delay = 8'd0;
        vecs[1].samp[7:4]   = {16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFF};
        vecs[2] = vecs[1];      vecs[2].thresh = 16'hFFFE;
        vecs[3].mask = 4'b1111; vecs[3].thresh = 16'd1000;    vecs[3].delay = 8'd1;
        vecs[3].samp[3:0]   = {4{fs_neg}};
        vecs[3].samp[15:12] = {4{fs_pos}};
        vecs[4].mask = 4'b1001; vecs[4].thresh = 16'(-100);   vecs[4].delay = 8'd2;
        vecs[5].mask = 4'b0100; vecs[5].thresh = 16'd0;       vecs[5].delay = 8'd0;
        vecs[5].samp[11:8]  = {16'd0, 16'd0, 16'd0, 16'd3};

        clear_counts();
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_conv_req", conv_if.conv_req, 0);
        chk("rst_pulses", {result_valid, scan_done, timeout_err}, 0);
        chk("rst_outputs", {result_ch, result_data, over_flags, conv_if.conv_ch}, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Continuous mode, stop raised during the third scan
        clear_counts();
        mode = 1'b1; ch_enable = 4'b1000; ack_delay = 0; thresh = 16'd0;
        for (int sc = 0; sc < 3; sc++) begin
            for (int k = 0; k < NSAMP; k++) s4[k] = DATA_W'($urandom);
            push_ch(3, s4);
        end
        start = 1'b1; tick(); start = 1'b0; mode = 1'b0;
        n = 0;
        while (sd_count < 2 && n < 200) begin tick(); n++; end
        chk("cont_two_scans", sd_count, 2);
        repeat (3) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        wait_idle(200, "cont");
        tick();
        chk("cont_scan_done", sd_count, 3);
        chk("cont_results", rv_count, 3);
        chk("cont_results_left", exp_q.size(), 0);
        chk("cont_flags", over_flags, exp_flags);

        // Front-end never acknowledges
        clear_counts();
        ch_enable = 4'b0001; no_ack = 1'b1; thresh = 16'd0;
        start = 1'b1; tick(); start = 1'b0;
        wait_idle(200, "tmo");
        tick();
        chk("tmo_req_cycles", req_hi, TIMEOUT);
        chk("tmo_err", timeout_err, 1);
        chk("tmo_results", rv_count, 0);
        chk("tmo_scan_done", sd_count, 0);
        no_ack = 1'b0; ack_delay = 0;
        clear_counts();
        push_ch(0, {16'd9, 16'd8, 16'd8, 16'd8});
        start = 1'b1; tick(); start = 1'b0;
        chk("tmo_cleared_by_start", timeout_err, 0);
        wait_idle(200, "tmo_recover");
        tick();
        chk("tmo_recover_left", exp_q.size(), 0);
        chk("tmo_recover_done", sd_count, 1);

        // Ack arrives in the last permitted REQ cycle
        clear_counts();
        ch_enable = 4'b0010; ack_delay = TIMEOUT - 1;
        push_ch(1, {16'(-6), 16'(-5), 16'(-5), 16'(-5)});
        start = 1'b1; tick(); start = 1'b0;
        wait_idle(1000, "late_ack");
        tick();
        chk("late_ack_err", timeout_err, 0);
        chk("late_ack_left", exp_q.size(), 0);
        chk("late_ack_reqs", req_pulses, NSAMP);
        chk("late_ack_flags", over_flags, exp_flags);
        ack_delay = 0;

        // start while busy must not disturb the running single scan
        clear_counts();
        ch_enable = 4'b0001; ack_delay = 1;
        push_ch(0, {16'd4, 16'd3, 16'd2, 16'd1});
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        ch_enable = 4'b1111; mode = 1'b1; start = 1'b1; tick(); start = 1'b0; mode = 1'b0;
        wait_idle(500, "busy_start");
        tick();
        chk("busy_start_results", rv_count, 1);
        chk("busy_start_done", sd_count, 1);
        chk("busy_start_reqs", req_pulses, NSAMP);
        chk("busy_start_left", exp_q.size(), 0);

        // start with an empty mask is ignored
        clear_counts();
        ch_enable = 4'b0000;
        start = 1'b1; tick(); busy_seen = busy; start = 1'b0;
        repeat (10) begin tick(); busy_seen |= busy; end
        chk("zmask_busy", busy_seen, 0);
        chk("zmask_pulses", rv_count + sd_count + req_pulses, 0);

        // Reset in the middle of a conversion request
        clear_counts();
        ch_enable = 4'b0100; ack_delay = 20;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!conv_if.conv_req && n < 10) begin tick(); n++; end
        chk("rst_mid_req_seen", conv_if.conv_req, 1);
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_mid_conv_req", conv_if.conv_req, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_outputs", {result_ch, result_data, over_flags, conv_if.conv_ch, timeout_err}, 0);
        exp_flags = '0;
        ack_delay = 0;
        run_vec(vecs[0], "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
